// File: rtl/chip_access_seq.sv
// Chip access sequencer: CE setup, per-chip strobe width, hold and ack/err handshakes.
// Optional macro CS_ONEHOT_CHECK_EN rejects requests whose chip selects are not one-hot.
module chip_access_seq #(
  parameter int T_SETUP  = 1,
  parameter int T_HOLD   = 1,
  parameter int WAIT_CS1 = 0,
  parameter int WAIT_CS2 = 1,
  parameter int WAIT_CS3 = 2,
  parameter int WAIT_CS4 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rd_wr,
  input  logic       CS1,
  input  logic       CS2,
  input  logic       CS3,
  input  logic       CS4,
  output logic [3:0] ce_n,
  output logic       oe_n,
  output logic       we_n,
  output logic       busy,
  output logic       ack,
  output logic       err
);

  localparam logic [3:0] TS = 4'(T_SETUP);
  localparam logic [3:0] TH = 4'(T_HOLD);
  localparam logic [3:0] W1 = 4'(WAIT_CS1);
  localparam logic [3:0] W2 = 4'(WAIT_CS2);
  localparam logic [3:0] W3 = 4'(WAIT_CS3);
  localparam logic [3:0] W4 = 4'(WAIT_CS4);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  chip, chip_next;
  logic        rd, rd_next;
  logic [3:0]  cs_low;
  logic [1:0]  sel_idx;
  logic        any_low, one_hot, accept, reject;
  logic [3:0]  ce_next;
  logic        oe_next, we_next, busy_next, ack_next, err_next;

  function automatic logic [3:0] wait_of(input logic [1:0] idx);
    case (idx)
      2'd0:    wait_of = W1;
      2'd1:    wait_of = W2;
      2'd2:    wait_of = W3;
      default: wait_of = W4;
    endcase
  endfunction

  assign cs_low  = ~{CS4, CS3, CS2, CS1};
  assign any_low = |cs_low;
  assign one_hot = any_low && ((cs_low & (cs_low - 4'd1)) == '0);

  always_comb begin
    sel_idx = 2'd3;
    if (cs_low[0])      sel_idx = 2'd0;
    else if (cs_low[1]) sel_idx = 2'd1;
    else if (cs_low[2]) sel_idx = 2'd2;
  end

`ifdef CS_ONEHOT_CHECK_EN
  assign accept = one_hot;
  assign reject = ~one_hot;
`else
  assign accept = any_low;
  assign reject = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    chip_next  = chip;
    rd_next    = rd;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (accept) begin
            chip_next = sel_idx;
            rd_next   = rd_wr;
            if (TS == 4'd0) begin
              state_next = STROBE;
              cnt_next   = wait_of(sel_idx);
            end else begin
              state_next = SETUP;
              cnt_next   = TS - 4'd1;
            end
          end else begin
            err_next = reject;
          end
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_next = STROBE;
          cnt_next   = wait_of(chip);
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          if (TH == 4'd0) begin
            state_next = DONE;
            cnt_next   = 4'd0;
          end else begin
            state_next = HOLD;
            cnt_next   = TH - 4'd1;
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    ce_next = '1;
    if (state_next == SETUP || state_next == STROBE || state_next == HOLD)
      ce_next[chip_next] = 1'b0;
    oe_next   = !(state_next == STROBE && rd_next);
    we_next   = !(state_next == STROBE && !rd_next);
    busy_next = (state_next != IDLE);
    ack_next  = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      chip  <= '0;
      rd    <= 1'b0;
      ce_n  <= '1;
      oe_n  <= 1'b1;
      we_n  <= 1'b1;
      busy  <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      chip  <= chip_next;
      rd    <= rd_next;
      ce_n  <= ce_next;
      oe_n  <= oe_next;
      we_n  <= we_next;
      busy  <= busy_next;
      ack   <= ack_next;
      err   <= err_next;
    end
  end

endmodule

// File: doc/chip_access_seq.md
CHIP_ACCESS_SEQ -- requirements
Module: chip_access_seq

Interface
REQ-001 Parameter T_SETUP, default 1: CE-to-strobe setup cycles, 4-bit range 0..15.
REQ-002 Parameter T_HOLD, default 1: strobe-release-to-CE-release hold cycles, 4-bit range 0..15.
REQ-003 Parameters WAIT_CS1/WAIT_CS2/WAIT_CS3/WAIT_CS4, defaults 0/1/2/3: extra strobe cycles per chip, 4-bit range 0..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  access request, sampled only while busy=0.
REQ-007 rd_wr  input  1  1=read, 0=write; sampled with req.
REQ-008 CS1, CS2, CS3, CS4  input  1 each  active-low chip selects from the address decoder.
REQ-009 ce_n  output  4  registered active-low chip enables; bit0=chip1 .. bit3=chip4.
REQ-010 oe_n  output  1  registered active-low read strobe.
REQ-011 we_n  output  1  registered active-low write strobe.
REQ-012 busy  output  1  high while an access is in progress.
REQ-013 ack  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse for a rejected request.

Function
REQ-015 FSM states: IDLE, SETUP, STROBE, HOLD, DONE; a 4-bit down-counter times SETUP, STROBE and HOLD.
REQ-016 IDLE, req=1, exactly one CSn low: latch chip index and rd_wr; next state SETUP (T_SETUP=0: STROBE); busy=1 from next cycle.
REQ-017 Latched chip's ce_n bit low in SETUP, STROBE and HOLD; all other ce_n bits stay high.
REQ-018 SETUP lasts T_SETUP cycles; oe_n/we_n high.
REQ-019 STROBE lasts 1+WAIT_CSn cycles for the latched chip; oe_n low if read, else we_n low; never both low.
REQ-020 HOLD lasts T_HOLD cycles (T_HOLD=0: skipped); strobes high, ce_n held.
REQ-021 DONE lasts one cycle: ack=1, busy=1, ce_n=4'b1111; next state IDLE.
REQ-022 Latency: ack is high exactly T_SETUP+1+WAIT_CSn+T_HOLD+1 cycles after the sampling edge.
REQ-023 req while busy=1 is ignored and not queued; next request is accepted in the cycle after DONE.
REQ-024 CS1..CS4 and rd_wr changes after the sampling edge do not affect an access in progress.
REQ-025 ack and err are never high in the same cycle.

Reset
REQ-026 rst_n=0 forces, asynchronously: state IDLE, counter 0, ce_n=4'b1111, oe_n=1, we_n=1, busy=0, ack=0, err=0.
REQ-027 Reset mid-access aborts it; no ack is issued; after release the block waits in IDLE for a new req.

Configuration
REQ-028 Macro CS_ONEHOT_CHECK_EN defined: req in IDLE with all CSn high or more than one CSn low produces err=1 for one cycle on the next cycle; no access starts; state stays IDLE.
REQ-029 CS_ONEHOT_CHECK_EN undefined: multiple low CSn resolve by priority CS1>CS2>CS3>CS4; req with all CSn high is ignored; err is tied 0.

Verification
REQ-030 Defaults, CS1 low, rd_wr=1, req pulse -> ce_n=4'b1110 for 3 cycles, oe_n low 1 cycle (the 2nd of those 3), ack 4 cycles after sampling edge, we_n stays high.
REQ-031 Defaults, CS4 low, rd_wr=0 -> we_n low 4 cycles, ce_n=4'b0111 for 6 cycles, ack 7 cycles after sampling edge.
REQ-032 T_SETUP=0, T_HOLD=0, CS2 low, read -> oe_n and ce_n[1] low together for 2 cycles, ack on the 3rd cycle.
REQ-033 req held high continuously with CS3 low -> back-to-back accesses separated by exactly one IDLE cycle; one ack per access.
REQ-034 With CS_ONEHOT_CHECK_EN: CS1 and CS2 both low, req -> err one cycle, ce_n stays 4'b1111, no ack; without the macro -> access to chip1.
REQ-035 rst_n low during STROBE of a write -> we_n, ce_n, busy go inactive immediately, no ack; next req after release completes normally.
